// File: rtl/z80_mem_responder.sv
// z80_mem_responder
//   Memory-side responder for the z80 bus. Decodes memory read/write cycles
//   that fall inside a 2**ADDR_BITS byte window at BASE_ADDR, stretches them
//   with WAIT_L for WAIT_STATES cycles, then services them from a synchronous
//   single-port SRAM with one cycle of read latency.
//
// Ports
//   clk, rst_L                  clock, asynchronous active-low reset
//   addr_bus, data_in           CPU address and write data
//   MREQ_L, IORQ_L, RD_L, WR_L,
//   RFSH_L                      z80 control strobes (active-low)
//   data_out, data_oe           read data and its bus drive enable
//   WAIT_L                      wait request to CPU (active-low)
//   bus_err                     1-cycle pulse on RD_L and WR_L both low
//   mem_addr, mem_wdata,
//   mem_we, mem_re, mem_rdata   SRAM interface
module z80_mem_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned ADDR_BITS   = 14,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic [15:0]          addr_bus,
    input  logic [7:0]           data_in,
    input  logic                 MREQ_L,
    input  logic                 IORQ_L,
    input  logic                 RD_L,
    input  logic                 WR_L,
    input  logic                 RFSH_L,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic                 WAIT_L,
    output logic                 bus_err,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWaits,
        StAcc,
        StRdat,
        StDrive,
        StDone
    } state_e;

    // Counter value on the last wait cycle.
    localparam int unsigned WaitLastInt = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0]  WaitLast    = WaitLastInt[3:0];

    state_e                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic                   is_write_q, is_write_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_oe_q, data_oe_d;
    logic                   wait_l_q, wait_l_d;
    logic                   bus_err_q, bus_err_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic                   illegal_q, illegal_d;

    logic hit;
    logic mem_cycle;
    logic req;

    assign hit       = (addr_bus >> ADDR_BITS) == (BASE_ADDR >> ADDR_BITS);
    assign mem_cycle = !MREQ_L && IORQ_L && RFSH_L && hit;
    assign req       = mem_cycle && (RD_L ^ WR_L);
    assign illegal_d = mem_cycle && !RD_L && !WR_L;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        is_write_d  = is_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_out_d  = data_out_q;
        bus_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    mem_addr_d  = addr_bus[ADDR_BITS-1:0];
                    mem_wdata_d = data_in;
                    is_write_d  = !WR_L;
                    wait_cnt_d  = 4'd0;
                    state_d     = (WAIT_STATES > 0) ? StWaits : StAcc;
                end else if (illegal_d && !illegal_q) begin
                    // Edge-detected so a held illegal combination gives one pulse.
                    bus_err_d = 1'b1;
                end
            end
            StWaits: begin
                if (MREQ_L) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StAcc;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StAcc: begin
                state_d = is_write_q ? StDone : StRdat;
            end
            StRdat: begin
                if (MREQ_L) begin
                    // CPU gave up: drop the read data.
                    state_d = StIdle;
                end else begin
                    data_out_d = mem_rdata;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (MREQ_L || RD_L) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (MREQ_L) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        mem_re_d  = (state_d == StAcc) && !is_write_d;
        mem_we_d  = (state_d == StAcc) && is_write_d;
        data_oe_d = (state_d == StDrive);
        wait_l_d  = !((state_d == StWaits) || (state_d == StAcc) || (state_d == StRdat));
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            is_write_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
            wait_l_q    <= 1'b1;
            bus_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            is_write_q  <= is_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            wait_l_q    <= wait_l_d;
            bus_err_q   <= bus_err_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            illegal_q   <= illegal_d;
        end
    end

    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign WAIT_L    = wait_l_q;
    assign bus_err   = bus_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench for z80_mem_responder. Three instances share one CPU bus:
// index 0 has WAIT_STATES=0, index 1 has 2, index 2 has 3. Each has a tiny
// SRAM model whose read data is addr[7:0] ^ 8'h79 (0x0123 -> 0x5A).
module tb_z80_mem_responder;

    logic        clk;
    logic        rst_L;
    logic [15:0] addr_bus;
    logic [7:0]  data_in;
    logic        MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

    logic [7:0]  dout   [3];
    logic        oe     [3];
    logic        wait_l [3];
    logic        berr   [3];
    logic [13:0] maddr  [3];
    logic [7:0]  mwd    [3];
    logic        mwe    [3];
    logic        mre    [3];
    logic [7:0]  rdata  [3];

    int n_wl  [3];
    int n_oe  [3];
    int n_re  [3];
    int n_we  [3];
    int n_err [3];

    int checks;
    int failures;

    z80_mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(14), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_in(data_in),
        .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .data_out(dout[0]), .data_oe(oe[0]), .WAIT_L(wait_l[0]), .bus_err(berr[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_we(mwe[0]), .mem_re(mre[0]),
        .mem_rdata(rdata[0])
    );

    z80_mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(14), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_in(data_in),
        .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .data_out(dout[1]), .data_oe(oe[1]), .WAIT_L(wait_l[1]), .bus_err(berr[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_we(mwe[1]), .mem_re(mre[1]),
        .mem_rdata(rdata[1])
    );

    z80_mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(14), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_in(data_in),
        .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .data_out(dout[2]), .data_oe(oe[2]), .WAIT_L(wait_l[2]), .bus_err(berr[2]),
        .mem_addr(maddr[2]), .mem_wdata(mwd[2]), .mem_we(mwe[2]), .mem_re(mre[2]),
        .mem_rdata(rdata[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models and per-cycle event counters (each posedge counts the
    // output values held during the cycle that ends there).
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mre[k]) rdata[k] <= maddr[k][7:0] ^ 8'h79;
            if (!wait_l[k]) n_wl[k] <= n_wl[k] + 1;
            if (oe[k]) n_oe[k] <= n_oe[k] + 1;
            if (mre[k]) n_re[k] <= n_re[k] + 1;
            if (mwe[k]) n_we[k] <= n_we[k] + 1;
            if (berr[k]) n_err[k] <= n_err[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1;
    endtask

    int b_wl, b_oe, b_re, b_we, b_err;
    int b_wl0, b_oe0, b_re0, b_we0;

    initial begin
        checks   = 0;
        failures = 0;
        rst_L    = 1'b0;
        addr_bus = 16'h0000;
        data_in  = 8'h00;
        bus_idle();

        // Reset state
        tick(2);
        chk("rst_wait_l",   32'(wait_l[1]), 32'h1);
        chk("rst_data_oe",  32'(oe[1]),     32'h0);
        chk("rst_data_out", 32'(dout[1]),   32'h0);
        chk("rst_bus_err",  32'(berr[1]),   32'h0);
        chk("rst_mem_re",   32'(mre[1]),    32'h0);
        chk("rst_mem_we",   32'(mwe[1]),    32'h0);
        chk("rst_mem_addr", 32'(maddr[1]),  32'h0);
        rst_L = 1'b1;
        tick(2);

        // Read 0x0123 with WAIT_STATES=2
        b_wl = n_wl[1]; b_re = n_re[1];
        addr_bus = 16'h0123; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(1);
        chk("rd_wait_first", 32'(wait_l[1]), 32'h0);
        tick(2);
        chk("rd_mem_re",      32'(mre[1]),   32'h1);
        chk("rd_mem_addr",    32'(maddr[1]), 32'h0123);
        tick(1);
        chk("rd_rdat_wait",   32'(wait_l[1]), 32'h0);
        chk("rd_rdat_oe",     32'(oe[1]),     32'h0);
        tick(1);
        chk("rd_drive_oe",    32'(oe[1]),     32'h1);
        chk("rd_drive_data",  32'(dout[1]),   32'h5A);
        chk("rd_drive_wait",  32'(wait_l[1]), 32'h1);
        tick(2);
        chk("rd_hold_oe",     32'(oe[1]),     32'h1);
        chk("rd_wait_cycles", 32'(n_wl[1] - b_wl), 32'd4);
        chk("rd_re_pulses",   32'(n_re[1] - b_re), 32'd1);
        RD_L = 1'b1; MREQ_L = 1'b1;
        tick(1);
        chk("rd_release_oe",  32'(oe[1]), 32'h0);
        tick(2);

        // Write 0xA5 to 0x3FFF with WAIT_STATES=2
        b_wl = n_wl[1]; b_we = n_we[1];
        addr_bus = 16'h3FFF; data_in = 8'hA5; MREQ_L = 1'b0; WR_L = 1'b0;
        tick(3);
        chk("wr_mem_we",    32'(mwe[1]),   32'h1);
        chk("wr_mem_addr",  32'(maddr[1]), 32'h3FFF);
        chk("wr_mem_wdata", 32'(mwd[1]),   32'hA5);
        tick(3);
        chk("wr_done_wait",   32'(wait_l[1]), 32'h1);
        chk("wr_wait_cycles", 32'(n_wl[1] - b_wl), 32'd3);
        chk("wr_we_pulses",   32'(n_we[1] - b_we), 32'd1);
        chk("wr_no_oe",       32'(oe[1]), 32'h0);
        bus_idle();
        tick(2);

        // No-response cycles: miss, refresh, I/O
        b_wl = n_wl[1]; b_oe = n_oe[1]; b_re = n_re[1]; b_we = n_we[1];
        addr_bus = 16'h4000; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(4);
        bus_idle();
        tick(1);
        addr_bus = 16'h0010; MREQ_L = 1'b0; RD_L = 1'b0; RFSH_L = 1'b0;
        tick(4);
        bus_idle();
        tick(1);
        addr_bus = 16'h0010; MREQ_L = 1'b0; RD_L = 1'b0; IORQ_L = 1'b0;
        tick(4);
        bus_idle();
        tick(1);
        chk("nr_wait_cycles", 32'(n_wl[1] - b_wl), 32'd0);
        chk("nr_oe_cycles",   32'(n_oe[1] - b_oe), 32'd0);
        chk("nr_re_pulses",   32'(n_re[1] - b_re), 32'd0);
        chk("nr_we_pulses",   32'(n_we[1] - b_we), 32'd0);
        tick(1);

        // Illegal RD_L and WR_L both low, held for two edges
        b_err = n_err[1]; b_re = n_re[1]; b_we = n_we[1]; b_wl = n_wl[1];
        addr_bus = 16'h0010; MREQ_L = 1'b0; RD_L = 1'b0; WR_L = 1'b0;
        tick(1);
        chk("err_pulse",     32'(berr[1]),   32'h1);
        chk("err_wait_l",    32'(wait_l[1]), 32'h1);
        tick(1);
        chk("err_pulse_end", 32'(berr[1]),   32'h0);
        bus_idle();
        tick(1);
        chk("err_count",  32'(n_err[1] - b_err), 32'd1);
        chk("err_no_acc", 32'(n_re[1] - b_re + n_we[1] - b_we), 32'd0);
        chk("err_no_wait", 32'(n_wl[1] - b_wl), 32'd0);
        tick(1);

        // Abort in the 2nd wait cycle with WAIT_STATES=3
        b_re = n_re[2]; b_oe = n_oe[2];
        addr_bus = 16'h0200; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(2);
        chk("abw_waiting", 32'(wait_l[2]), 32'h0);
        bus_idle();
        tick(1);
        chk("abw_released", 32'(wait_l[2]), 32'h1);
        tick(3);
        chk("abw_no_re", 32'(n_re[2] - b_re), 32'd0);
        chk("abw_no_oe", 32'(n_oe[2] - b_oe), 32'd0);

        // Abort in RDAT with WAIT_STATES=0: data dropped, never driven
        b_re0 = n_re[0]; b_oe0 = n_oe[0];
        addr_bus = 16'h0042; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(1);
        chk("abr_mem_re", 32'(mre[0]), 32'h1);
        tick(1);
        chk("abr_rdat_wait", 32'(wait_l[0]), 32'h0);
        bus_idle();
        tick(1);
        chk("abr_wait_l", 32'(wait_l[0]), 32'h1);
        tick(1);
        chk("abr_no_oe",  32'(n_oe[0] - b_oe0), 32'd0);
        chk("abr_one_re", 32'(n_re[0] - b_re0), 32'd1);

        // Asynchronous reset while driving, then a normal WAIT_STATES=0 read
        addr_bus = 16'h0042; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(3);
        chk("ar_drive_oe",   32'(oe[0]),   32'h1);
        chk("ar_drive_data", 32'(dout[0]), 32'h3B);
        #2 rst_L = 1'b0;
        #1;
        chk("ar_oe",    32'(oe[0]),     32'h0);
        chk("ar_wait",  32'(wait_l[0]), 32'h1);
        chk("ar_data",  32'(dout[0]),   32'h0);
        bus_idle();
        tick(1);
        rst_L = 1'b1;
        tick(2);
        b_wl0 = n_wl[0]; b_we0 = n_we[0];
        addr_bus = 16'h0042; MREQ_L = 1'b0; RD_L = 1'b0;
        tick(3);
        chk("ar_read_oe",   32'(oe[0]),   32'h1);
        chk("ar_read_data", 32'(dout[0]), 32'h3B);
        bus_idle();
        tick(2);
        chk("ar_read_wait_cycles", 32'(n_wl[0] - b_wl0), 32'd2);
        chk("ar_read_no_we",       32'(n_we[0] - b_we0), 32'd0);
        chk("ar_read_oe_off",      32'(oe[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_mem_responder.md
Name: z80_mem_responder

Overview:
- Memory-side responder for the z80 CPU bus. It decodes CPU memory read and write cycles that fall inside a configurable address window.
- It stretches each cycle with WAIT_L for a programmable number of wait states, then services it from a synchronous single-port SRAM with 1-cycle read latency.
- It sits between the z80 bus pins and an on-chip RAM. The top level merges data_out/data_oe onto the tri-state data_bus.

Parameters:
- BASE_ADDR, 16'h0000, base of the decoded window; only bits above ADDR_BITS are compared.
- ADDR_BITS, 14, window size is 2**ADDR_BITS bytes; also the mem_addr width.
- WAIT_STATES, 1, extra wait cycles inserted before the SRAM access; legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst_L  input  1  reset; asynchronous, active-low.
- addr_bus  input  16  CPU address.
- data_in  input  8  CPU write data, taken from data_bus.
- MREQ_L  input  1  memory request, active-low.
- IORQ_L  input  1  I/O request, active-low.
- RD_L  input  1  read strobe, active-low.
- WR_L  input  1  write strobe, active-low.
- RFSH_L  input  1  refresh cycle indicator, active-low.
- data_out  output  8  read data to be driven onto data_bus.
- data_oe  output  1  high when data_out must drive data_bus.
- WAIT_L  output  1  wait request to CPU, active-low.
- bus_err  output  1  1-cycle pulse on an illegal strobe combination.
- mem_addr  output  ADDR_BITS  SRAM address.
- mem_wdata  output  8  SRAM write data.
- mem_we  output  1  SRAM write enable, 1-cycle pulse.
- mem_re  output  1  SRAM read enable, 1-cycle pulse.
- mem_rdata  input  8  SRAM read data, valid the cycle after mem_re.

Behaviour:
- All bus inputs are sampled at the rising edge of clk. All outputs are registered.
- Reset values (applied asynchronously on rst_L low):
  - state=IDLE, data_out=0, data_oe=0, WAIT_L=1, bus_err=0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, wait counter=0.
- hit = (addr_bus >> ADDR_BITS) == (BASE_ADDR >> ADDR_BITS).
- req = !MREQ_L && IORQ_L && RFSH_L && hit && (RD_L xor WR_L).
- States:
  - IDLE: on req, latch addr_bus[ADDR_BITS-1:0] into mem_addr, latch data_in into mem_wdata, latch is_write=!WR_L, and clear the wait counter. Go to WAITS if WAIT_STATES>0, else ACC. If !MREQ_L && RFSH_L && IORQ_L && hit && !RD_L && !WR_L: pulse bus_err, stay in IDLE.
  - WAITS: count up; after WAIT_STATES cycles go to ACC.
  - ACC: mem_re=1 for a read, or mem_we=1 for a write, for exactly this cycle. Next state is RDAT for a read, DONE for a write.
  - RDAT: capture mem_rdata into data_out; next state is DRIVE.
  - DRIVE: data_oe=1. Stay while !MREQ_L && !RD_L; otherwise go to IDLE.
  - DONE: stay while !MREQ_L; otherwise go to IDLE.
- WAIT_L=0 exactly while state is WAITS, ACC or RDAT.
  - Reads are stretched WAIT_STATES+2 cycles.
  - Writes are stretched WAIT_STATES+1 cycles.
- data_oe is 1 only in DRIVE. It deasserts in the cycle after the release of MREQ_L or RD_L is sampled.
- A new req is not accepted until the FSM has returned to IDLE. Back-to-back cycles need MREQ_L to go high for at least one sampled edge.
- Abort: if MREQ_L is sampled high in WAITS, go to IDLE and issue no mem_we/mem_re. If it is sampled high in RDAT, go to IDLE and discard the read data; data_oe is never asserted.
- Cycles that produce no response (WAIT_L stays 1, data_oe stays 0, no mem strobe):
  - address miss
  - refresh cycle
  - I/O cycle
- Reset mid-operation: all outputs return to reset values immediately. Any pending SRAM access is dropped.

Test Plan:
- WAIT_STATES=2, SRAM[0x0123]=0x5A, CPU read 0x0123 -> WAIT_L low 4 cycles; mem_re pulse with mem_addr=0x0123; then data_out=0x5A with data_oe=1 and WAIT_L=1 until RD_L rises; data_oe=0 one cycle later.
- WAIT_STATES=2, CPU write 0xA5 to 0x3FFF -> WAIT_L low 3 cycles; a single mem_we pulse with mem_addr=0x3FFF, mem_wdata=0xA5; FSM returns to IDLE after MREQ_L rises.
- Read 0x4000 (miss, ADDR_BITS=14), plus MREQ_L=0 with RFSH_L=0, plus an IORQ_L=0 cycle -> WAIT_L=1, data_oe=0, no mem strobes throughout.
- MREQ_L=0 with RD_L=0 and WR_L=0 at 0x0010 -> bus_err pulses for 1 cycle; no mem access; WAIT_L=1.
- WAIT_STATES=3, read starts, MREQ_L released in the 2nd wait cycle -> IDLE next cycle; WAIT_L=1; mem_re never asserted; data_oe=0.
- rst_L driven low while in DRIVE with data_oe=1 -> data_oe=0, WAIT_L=1, data_out=0 without waiting for a clock edge; after release, a normal read at WAIT_STATES=0 gives WAIT_L low for exactly 2 cycles.
